// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU output mux.
// Keeps a running sum of stored results and counts dropped select-0 results.
module alu_result_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_sel,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_sel,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       acc_clr,
  output logic [WIDTH+3:0]           acc_sum,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic L_DZ = (DROP_ZERO != 0);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [1:0]       r_sel  [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH+3:0] r_acc;
  logic [7:0]       r_drop;

  logic w_accept;
  logic w_drop;
  logic w_store;
  logic w_pop;
  logic [WIDTH+3:0] w_ext;

  assign in_ready  = rst_n && (r_count < L_FULL);
  assign out_valid = rst_n && (r_count != '0);

  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && L_DZ && (in_sel == 2'd0);
  assign w_store  = w_accept && !w_drop;
  assign w_pop    = out_valid && out_ready;
  assign w_ext    = {4'b0, in_data};

  assign out_data = out_valid ? r_data[r_rptr] : '0;
  assign out_sel  = out_valid ? r_sel[r_rptr] : 2'd0;
  assign count    = r_count;
  assign acc_sum  = r_acc;
  assign drop_cnt = r_drop;

  // Storage needs no reset; emptiness is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_data[r_wptr] <= in_data;
      r_sel[r_wptr]  <= in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_drop  <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      unique case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (acc_clr)      r_acc <= w_store ? w_ext : '0;
      else if (w_store) r_acc <= r_acc + w_ext;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo (WIDTH=8, DEPTH=4, DROP_ZERO=1).
// Expected values are hand-computed per step.
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
  logic [7:0]  out_data;
  logic [2:0]  count;
  logic        acc_clr;
  logic [11:0] acc_sum;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  alu_result_fifo #(.WIDTH(8), .DEPTH(4), .DROP_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_data(out_data),
    .count(count), .acc_clr(acc_clr),
    .acc_sum(acc_sum), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_sel = 0; in_data = 0;
    out_ready = 0; acc_clr = 0;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc", 32'(acc_sum), 0);
    chk("rst_drop", 32'(drop_cnt), 0);

    rst_n = 1;
    #1;
    chk("ready_after_rst", 32'(in_ready), 1);
    push(2'd1, 8'd14);
    chk("first_count", 32'(count), 1);
    chk("first_out_valid", 32'(out_valid), 1);
    chk("first_out_data", 32'(out_data), 14);
    push(2'd1, 8'd2);
    push(2'd1, 8'd9);
    push(2'd1, 8'd7);
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_acc", 32'(acc_sum), 32);

    in_valid = 1; in_sel = 2'd1; in_data = 8'd5;
    step(); step(); step();
    chk("bp_count", 32'(count), 4);
    chk("bp_acc", 32'(acc_sum), 32);
    chk("bp_head", 32'(out_data), 14);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_pop_count", 32'(count), 3);
    chk("bp_pop_head", 32'(out_data), 2);
    step();
    in_valid = 0;
    chk("bp_accept_count", 32'(count), 4);
    chk("bp_accept_acc", 32'(acc_sum), 37);

    out_ready = 1;
    chk("drain0", 32'(out_data), 2); step();
    chk("drain1", 32'(out_data), 9); step();
    chk("drain2", 32'(out_data), 7); step();
    chk("drain3", 32'(out_data), 5); step();
    out_ready = 0;
    chk("empty_count", 32'(count), 0);
    chk("empty_valid", 32'(out_valid), 0);
    chk("empty_data", 32'(out_data), 0);

    push(2'd1, 8'd10);
    push(2'd1, 8'd20);
    chk("sim_pre_count", 32'(count), 2);
    out_ready = 1;
    push(2'd1, 8'd3);
    chk("sim_count", 32'(count), 2);
    chk("sim_acc", 32'(acc_sum), 70);
    for (int i = 0; i < 6; i++) begin
      chk("sim_head", 32'(out_data), (i == 0) ? 20 : (i == 1) ? 3 : 38 + i);
      push(2'd1, 8'(40 + i));
      chk("sim_loop_count", 32'(count), 2);
    end
    chk("sim_acc_end", 32'(acc_sum), 325);
    chk("sim_tail0", 32'(out_data), 44); step();
    chk("sim_tail1", 32'(out_data), 45); step();
    out_ready = 0;
    chk("sim_drained", 32'(count), 0);

    push(2'd0, 8'd0);
    push(2'd0, 8'd0);
    push(2'd0, 8'd0);
    chk("drop_cnt3", 32'(drop_cnt), 3);
    chk("drop_count0", 32'(count), 0);
    chk("drop_acc", 32'(acc_sum), 325);
    push(2'd2, 8'd14);
    chk("drop_keep_count", 32'(count), 1);
    chk("drop_keep_sel", 32'(out_sel), 2);
    chk("drop_keep_data", 32'(out_data), 14);
    chk("drop_keep_acc", 32'(acc_sum), 339);
    out_ready = 1;
    step();
    out_ready = 0;

    acc_clr = 1;
    step();
    acc_clr = 0;
    chk("clr_acc", 32'(acc_sum), 0);
    out_ready = 1;
    for (int i = 0; i < 17; i++) push(2'd1, 8'd255);
    out_ready = 0;
    chk("wrap_acc", 32'(acc_sum), 239);
    chk("wrap_count", 32'(count), 1);
    acc_clr = 1;
    push(2'd1, 8'd6);
    acc_clr = 0;
    chk("clr_store_acc", 32'(acc_sum), 6);
    chk("clr_store_count", 32'(count), 2);
    chk("drop_hold", 32'(drop_cnt), 3);

    push(2'd3, 8'd33);
    chk("mid_count3", 32'(count), 3);
    rst_n = 0; in_valid = 1; in_sel = 2'd1; in_data = 8'd99;
    out_ready = 1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 0);
    chk("mid_out_valid", 32'(out_valid), 0);
    step();
    rst_n = 1; in_valid = 0; out_ready = 0;
    #1;
    chk("mid_count", 32'(count), 0);
    chk("mid_acc", 32'(acc_sum), 0);
    chk("mid_drop", 32'(drop_cnt), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", 32'(out_data), 0);
    push(2'd1, 8'd77);
    chk("post_rst_data", 32'(out_data), 77);
    chk("post_rst_count", 32'(count), 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("post_rst_empty", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: WIDTH, default 8, result data width; matches the ALU-mux z output.
REQ-002 Parameter: DEPTH, default 4, number of FIFO entries; power of two, >= 2.
REQ-003 Parameter: DROP_ZERO, default 1; when 1, results tagged select 2'd0 are accepted but not stored.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream result valid.
REQ-007 in_ready  output  1  block can accept a result this cycle.
REQ-008 in_sel  input  2  select code that produced in_data (ALU-mux select).
REQ-009 in_data  input  WIDTH  ALU-mux result z.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 out_sel  output  2  select tag of head entry.
REQ-013 out_data  output  WIDTH  data of head entry.
REQ-014 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-015 acc_clr  input  1  clear running sum.
REQ-016 acc_sum  output  WIDTH+4  running sum of stored in_data values, modulo 2^(WIDTH+4).
REQ-017 drop_cnt  output  8  number of dropped select-0 results, saturating at 255.

Function
REQ-018 Accept occurs on an edge with in_valid=1 and in_ready=1; pop occurs on an edge with out_valid=1 and out_ready=1.
REQ-019 in_ready shall be 1 iff rst_n=1 and count<DEPTH; in_ready shall not depend on out_ready, so there is no push-when-full bypass.
REQ-020 out_valid shall be 1 iff count!=0; when count=0, out_data and out_sel shall be 0.
REQ-021 A stored entry shall appear on out_data/out_sel after the accepting edge, giving first-word latency of 1 cycle and no combinational in-to-out path.
REQ-022 Entries shall pop in acceptance order; write and read pointers shall wrap modulo DEPTH.
REQ-023 For a store with no pop, count shall increment by 1; for a pop with no store, count shall decrement by 1; for a simultaneous store and pop, count shall be unchanged.
REQ-024 With DROP_ZERO=1, an accept with in_sel=2'd0 shall not store the entry, shall not change count or acc_sum, and shall increment drop_cnt (saturating at 255); in_ready shall still follow REQ-019.
REQ-025 With DROP_ZERO=0, every accept shall store the entry.
REQ-026 Each stored entry shall add zero-extended in_data to acc_sum, with wrap on overflow.
REQ-027 acc_clr=1 without a store shall set acc_sum to 0; acc_clr=1 together with a store shall set acc_sum to in_data.
REQ-028 A pop shall not alter acc_sum.
REQ-029 Status outputs count, acc_sum and drop_cnt shall be registered; in_ready and out_valid shall be derived combinationally from registered count and rst_n only.

Reset
REQ-030 While rst_n=0 at an edge: pointers, count, acc_sum and drop_cnt shall become 0, and all stored entries shall be discarded.
REQ-031 While rst_n=0, in_ready=0 and out_valid=0.
REQ-032 Reset asserted mid-transfer shall take priority over a simultaneous accept or pop; no handshake completes on that edge.
REQ-033 The first accept after reset shall be possible on the first edge with rst_n=1.

Verification
REQ-034 Fill/drain (DEPTH=4): accept sel=1 data 14,2,9,7 -> count=4, in_ready=0, acc_sum=32; pop 4 times -> out_data 14,2,9,7 in order, count=0, out_data=0.
REQ-035 Full backpressure: with 4 entries stored, in_valid=1 with data 5 for 3 cycles and out_ready=0 -> no accept, count stays 4; then 1 pop -> next edge accepts 5.
REQ-036 Simultaneous events: count=2, accept data 3 while popping -> count stays 2, wrap-around order preserved across 6 further pushes/pops.
REQ-037 Drop path: accept sel=0 data 0 three times, then sel=2 data 14 -> drop_cnt=3, count=1, out_sel=2, acc_sum increases by 14 only.
REQ-038 Sum wrap and clear: accept 17 entries of 255 with pops -> acc_sum=4335 mod 4096=239; acc_clr together with accept of 6 -> acc_sum=6.
REQ-039 Reset mid-operation: count=3, rst_n=0 for 1 edge while in_valid=1 and out_ready=1 -> count=0, acc_sum=0, drop_cnt=0, out_valid=0; old data never reappears.
